// File: rtl/snn_step_ctrl.sv
// Timestep sequencer for the 32-neuron SNN core. Each timestep runs SET, then N_NUM
// accumulate cycles, a drain/decay pair, PDE and FINISH. Timesteps repeat num_steps times per run.
module snn_step_ctrl #(
  parameter int N_NUM = 32,
  parameter int N_SZ  = 5,
  parameter int ST_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ST_W-1:0]  num_steps,
  input  logic [N_NUM-1:0] spike_in,
  input  logic [N_NUM-1:0] fire_in,
  output logic [2:0]       state,
  output logic             busy,
  output logic             set_en,
  output logic             shift_en,
  output logic             syn_en,
  output logic [N_SZ-1:0]  w_addr,
  output logic             decay_en,
  output logic             pde_en,
  output logic [N_NUM-1:0] spike_out,
  output logic [ST_W-1:0]  step_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_SET      = 3'b001,
    S_SYN_ACCU = 3'b010,
    S_DECAY    = 3'b011,
    S_PDE      = 3'b100,
    S_FINISH   = 3'b101,
    S_DONE     = 3'b110
  } state_e;

  state_e           state_q, state_d;
  logic [N_SZ-1:0]  cnt_q, cnt_d;
  logic [ST_W-1:0]  step_cnt_q, step_cnt_d;
  logic [ST_W-1:0]  steps_q, steps_d;
  logic [N_NUM-1:0] spk_lat_q, spk_lat_d;
  logic [N_NUM-1:0] spike_out_q, spike_out_d;
  logic             dcy_q, dcy_d;
  logic [ST_W:0]    step_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_cnt_q  <= '0;
      steps_q     <= '0;
      spk_lat_q   <= '0;
      spike_out_q <= '0;
      dcy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_cnt_q  <= step_cnt_d;
      steps_q     <= steps_d;
      spk_lat_q   <= spk_lat_d;
      spike_out_q <= spike_out_d;
      dcy_q       <= dcy_d;
    end
  end

  // One bit wider so the compare against a 255-step run cannot overflow.
  assign step_next = {1'b0, step_cnt_q} + (ST_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_cnt_d  = step_cnt_q;
    steps_d     = steps_q;
    spk_lat_d   = spk_lat_q;
    spike_out_d = spike_out_q;
    dcy_d       = dcy_q;
    set_en      = 1'b0;
    shift_en    = 1'b0;
    syn_en      = 1'b0;
    decay_en    = 1'b0;
    pde_en      = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          steps_d    = (num_steps == '0) ? ST_W'(1) : num_steps;
          step_cnt_d = '0;
          state_d    = S_SET;
        end
      end
      S_SET: begin
        set_en    = 1'b1;
        spk_lat_d = spike_in;
        cnt_d     = '0;
        state_d   = S_SYN_ACCU;
      end
      S_SYN_ACCU: begin
        shift_en = 1'b1;
        syn_en   = spk_lat_q[cnt_q];
        if (cnt_q == N_SZ'(N_NUM - 1)) begin
          cnt_d   = '0;
          dcy_d   = 1'b0;
          state_d = S_DECAY;
        end else begin
          cnt_d = cnt_q + N_SZ'(1);
        end
      end
      // First DECAY cycle drains the synapse pipeline; decay fires on the second.
      S_DECAY: begin
        if (dcy_q) begin
          decay_en = 1'b1;
          dcy_d    = 1'b0;
          state_d  = S_PDE;
        end else begin
          dcy_d = 1'b1;
        end
      end
      S_PDE: begin
        pde_en  = 1'b1;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        spike_out_d = fire_in;
        step_cnt_d  = step_next[ST_W-1:0];
        if (step_next < {1'b0, steps_q}) state_d = S_SET;
        else                             state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state     = state_q;
  assign busy      = (state_q != S_IDLE);
  assign w_addr    = cnt_q;
  assign spike_out = spike_out_q;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_snn_step_ctrl.sv
// Bench for snn_step_ctrl: a timeline model (offset since first SET) predicts every output
// each cycle, and literal expectations pin the directed scenarios.
module tb_snn_step_ctrl;
  localparam int PER = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  numSteps = '0;
  logic [31:0] spikeIn = '0;
  logic [31:0] fireIn = '0;
  logic [2:0]  state;
  logic        busy, set_en, shift_en, syn_en, decay_en, pde_en, done;
  logic [4:0]  w_addr;
  logic [31:0] spike_out;
  logic [7:0]  step_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snn_step_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(numSteps),
    .spike_in(spikeIn), .fire_in(fireIn), .state(state), .busy(busy),
    .set_en(set_en), .shift_en(shift_en), .syn_en(syn_en), .w_addr(w_addr),
    .decay_en(decay_en), .pde_en(pde_en), .spike_out(spike_out),
    .step_cnt(step_cnt), .done(done)
  );

  // Model: a run is a timeline of PER-cycle timesteps starting at offset 0 (SET),
  // followed by a single DONE cycle at offset PER*steps.
  bit          mActive = 0;
  int          mT = 0;
  int          mSteps = 1;
  logic [31:0] mLat = '0;
  logic [31:0] mSpikeOut = '0;
  int          mStepCnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mActive   <= 0;
      mT        <= 0;
      mSteps    <= 1;
      mLat      <= '0;
      mSpikeOut <= '0;
      mStepCnt  <= 0;
    end else if (!mActive) begin
      if (start) begin
        mActive  <= 1;
        mT       <= 0;
        mSteps   <= (numSteps == 0) ? 1 : int'(numSteps);
        mStepCnt <= 0;
      end
    end else if (mT == PER * mSteps) begin
      mActive <= 0;
    end else begin
      if (mT % PER == 0) mLat <= spikeIn;
      if (mT % PER == PER - 1) begin
        mSpikeOut <= fireIn;
        mStepCnt  <= mStepCnt + 1;
      end
      mT <= mT + 1;
    end
  end

  function automatic logic [14:0] expCtrl();
    logic [2:0] st;
    logic b, s, sh, sy, dc, pd, dn;
    logic [4:0] a;
    int ph;
    st = 0; b = 0; s = 0; sh = 0; sy = 0; dc = 0; pd = 0; dn = 0; a = 0;
    if (mActive) begin
      b = 1;
      if (mT == PER * mSteps) begin
        st = 3'd6; dn = 1;
      end else begin
        ph = mT % PER;
        if (ph == 0) begin
          st = 3'd1; s = 1;
        end else if (ph <= 32) begin
          st = 3'd2; sh = 1; a = 5'(ph - 1); sy = mLat[ph - 1];
        end else if (ph <= 34) begin
          st = 3'd3; dc = (ph == 34);
        end else if (ph == 35) begin
          st = 3'd4; pd = 1;
        end else begin
          st = 3'd5;
        end
      end
    end
    return {st, b, s, sh, sy, a, dc, pd, dn};
  endfunction

  task automatic checkOutput(input string name);
    logic [14:0] gotC, expC;
    logic [39:0] gotD, expD;
    gotC = {state, busy, set_en, shift_en, syn_en, w_addr, decay_en, pde_en, done};
    expC = expCtrl();
    gotD = {spike_out, step_cnt};
    expD = {mSpikeOut, 8'(mStepCnt)};
    checks++;
    if (gotC !== expC) begin
      failures++;
      $display("[TB] FAIL %s_ctrl t=%0t: got %b required %b", name, $time, gotC, expC);
    end
    checks++;
    if (gotD !== expD) begin
      failures++;
      $display("[TB] FAIL %s_data t=%0t: got %h required %h", name, $time, gotD, expD);
    end
  endtask

  always @(negedge clk) checkOutput("cycle");

  task automatic checkLit(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one start..DONE sequence. cycles counts SET through DONE inclusive.
  task automatic applyStimulus(input logic [7:0] n, input bit rndData, input bit pokeStart,
                               input bit seqMode, output int cycles, output int shifts,
                               output logic [95:0] masks);
    int pass;
    int limit;
    bit gotDone;
    pass = 0; shifts = 0; masks = '0; cycles = 0; gotDone = 0;
    limit = PER * ((n == 0) ? 1 : int'(n)) + 20;
    numSteps = n;
    start = 1;
    tick();
    start = 0;
    numSteps = 8'($urandom);
    while (!gotDone && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (set_en) pass++;
      if (shift_en) shifts++;
      if (syn_en && pass >= 1 && pass <= 3) masks[(pass - 1) * 32 + int'(w_addr)] = 1'b1;
      if (done) gotDone = 1;
      else begin
        tick();
        if (rndData) begin
          spikeIn = $urandom;
          fireIn  = $urandom;
        end
        if (pokeStart) start = (state == 3'd2 || state == 3'd6);
        if (seqMode && state == 3'd2 && w_addr == 0) spikeIn = 32'd1 << pass;
      end
    end
    if (!gotDone) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles required done", cycles);
    end
    tick();
    start = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, sh;
    logic [95:0] mk;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'($urandom_range(0, 1));
      numSteps = 8'($urandom);
      spikeIn = $urandom;
      fireIn = $urandom;
    end
    @(negedge clk);
    checkLit("rst_state", state, 0);
    checkLit("rst_busy", busy, 0);
    checkLit("rst_strobes", {set_en, shift_en, syn_en, decay_en, pde_en, done}, 0);
    checkLit("rst_spike_out", spike_out, 0);
    checkLit("rst_step_cnt", step_cnt, 0);
    tick();
    start = 0;
    rst = 1;
    repeat (5) tick();
    checkLit("idle_no_start", state, 0);

    // Single step.
    spikeIn = 32'h0000_0005;
    fireIn = 32'h8000_0001;
    applyStimulus(8'd1, 0, 0, 0, cyc, sh, mk);
    checkLit("s1_shift_count", sh, 32);
    checkLit("s1_syn_addrs", mk[31:0], 32'h5);
    checkLit("s1_spike_out", spike_out, 32'h8000_0001);
    checkLit("s1_step_cnt", step_cnt, 1);
    checkLit("s1_cycles", cyc, 38);

    // Three steps with a new spike vector per SET.
    spikeIn = 32'h1;
    applyStimulus(8'd3, 0, 0, 1, cyc, sh, mk);
    checkLit("s3_mask0", mk[31:0], 32'h1);
    checkLit("s3_mask1", mk[63:32], 32'h2);
    checkLit("s3_mask2", mk[95:64], 32'h4);
    checkLit("s3_cycles", cyc, 112);
    checkLit("s3_step_cnt", step_cnt, 3);

    // num_steps=0 behaves as one step.
    applyStimulus(8'd0, 1, 0, 0, cyc, sh, mk);
    checkLit("s0_cycles", cyc, 38);
    checkLit("s0_step_cnt", step_cnt, 1);

    // start pulsed during SYN_ACCU and DONE is ignored.
    applyStimulus(8'd2, 1, 1, 0, cyc, sh, mk);
    checkLit("poke_cycles", cyc, 75);
    tick();
    checkLit("poke_idle", state, 0);

    // Asynchronous reset in the middle of SYN_ACCU.
    numSteps = 8'd2;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 3'd2 && w_addr == 5'd10) break;
    end
    checkLit("pre_rst_addr", w_addr, 10);
    #2 rst = 0;
    #1;
    checkLit("arst_state", state, 0);
    checkLit("arst_busy_strobes", {busy, set_en, shift_en, syn_en, decay_en, pde_en, done}, 0);
    checkLit("arst_addr", w_addr, 0);
    checkLit("arst_data", {spike_out, step_cnt}, 0);
    checkOutput("arst");
    tick();
    tick();
    rst = 1;
    tick();
    spikeIn = 32'hA5A5_0F0F;
    applyStimulus(8'd1, 0, 0, 0, cyc, sh, mk);
    checkLit("post_rst_cycles", cyc, 38);
    checkLit("post_rst_syn", mk[31:0], 32'hA5A5_0F0F);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      applyStimulus(8'($urandom_range(0, 4)), 1, 1, 0, cyc, sh, mk);
    end

    // Longest run: step_cnt reaches the maximum steps value.
    applyStimulus(8'd255, 1, 0, 0, cyc, sh, mk);
    checkLit("s255_cycles", cyc, 37 * 255 + 1);
    checkLit("s255_step_cnt", step_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
